// File: rtl/system_bus_pkg.sv
// system_bus_pkg: shared master identifiers for the system bus arbiter
package system_bus_pkg;
    typedef enum logic {MASTER_IFETCH = 1'b0, MASTER_DATA = 1'b1} master_id_t;
    localparam int NUM_MASTERS = 2;
endpackage

// File: rtl/read_tag_fifo.sv
// read_tag_fifo: in-order FIFO of master tags for reads still in flight
module read_tag_fifo
    import system_bus_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = master_id_t
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  T                       push_data,
    input  logic                   pop,
    output T                       head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    T mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic do_push, do_pop;
    // Guard against overflow/underflow; pointers wrap naturally as DEPTH is a power of two
    always_comb begin
        do_push = push & (count_q != CW'(DEPTH));
        do_pop  = pop & (count_q != '0);
        wr_d    = do_push ? wr_q + 1'b1 : wr_q;
        rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end
    // Tag storage needs no reset: entries are only read once pushed
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= push_data;
    end
    assign head  = mem_q[rd_q];
    assign count = count_q;
endmodule

// File: rtl/system_bus_arbiter.sv
// system_bus_arbiter: round-robin sharing of the system bus between ifetch and data masters
module system_bus_arbiter
    import system_bus_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                             clk,
    input  logic                             reset_n,
    output logic                             if_ready,
    input  logic [29:0]                      if_addr,
    input  logic [3:0]                       if_byte_enable,
    input  logic                             if_read_req,
    output logic [31:0]                      if_read_data,
    output logic                             if_read_data_valid,
    output logic                             dm_ready,
    input  logic [29:0]                      dm_addr,
    input  logic [31:0]                      dm_write_data,
    input  logic [3:0]                       dm_byte_enable,
    input  logic                             dm_read_req,
    input  logic                             dm_write_req,
    output logic [31:0]                      dm_read_data,
    output logic                             dm_read_data_valid,
    input  logic                             bus_ready,
    output logic [29:0]                      bus_addr,
    output logic [31:0]                      bus_write_data,
    output logic [3:0]                       bus_byte_enable,
    output logic                             bus_read_req,
    output logic                             bus_write_req,
    input  logic [31:0]                      bus_read_data,
    input  logic                             bus_read_data_valid,
    output logic [$clog2(MAX_OUTSTANDING):0] outstanding_count,
    output logic                             protocol_error
);
    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(MAX_OUTSTANDING);
    master_id_t last_grant_q, last_grant_d, grant_id, head;
    logic protocol_error_q, protocol_error_d;
    logic full, dm_write, if_elig, dm_elig, gnt_if, gnt_dm, accept, push, pop;
    // Eligibility, round-robin grant and bus mux; everything is gated off while in reset
    always_comb begin
        full            = outstanding_count == FULL_COUNT;
        dm_write        = dm_write_req & ~dm_read_req;
        if_elig         = reset_n & if_read_req & ~full;
        dm_elig         = reset_n & (dm_write | (dm_read_req & ~full));
        gnt_dm          = dm_elig & (~if_elig | (last_grant_q == MASTER_IFETCH));
        gnt_if          = if_elig & ~gnt_dm;
        grant_id        = gnt_dm ? MASTER_DATA : MASTER_IFETCH;
        accept          = bus_ready & (gnt_if | gnt_dm);
        if_ready        = bus_ready & gnt_if;
        dm_ready        = bus_ready & gnt_dm;
        bus_addr        = gnt_dm ? dm_addr : if_addr;
        bus_write_data  = gnt_dm ? dm_write_data : '0;
        bus_byte_enable = gnt_dm ? dm_byte_enable : if_byte_enable;
        bus_read_req    = gnt_if | (gnt_dm & dm_read_req);
        bus_write_req   = gnt_dm & dm_write;
        push            = accept & bus_read_req;
        pop             = reset_n & bus_read_data_valid & (outstanding_count != '0);
        last_grant_d    = accept ? grant_id : last_grant_q;
        protocol_error_d = protocol_error_q
                         | (bus_read_data_valid & (outstanding_count == '0))
                         | (dm_read_req & dm_write_req);
    end
    // Round-robin history and sticky error flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q     <= MASTER_IFETCH;
            protocol_error_q <= 1'b0;
        end else begin
            last_grant_q     <= last_grant_d;
            protocol_error_q <= protocol_error_d;
        end
    end
    read_tag_fifo #(.DEPTH(MAX_OUTSTANDING), .T(master_id_t)) u_tags (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (push),
        .push_data(grant_id),
        .pop      (pop),
        .head     (head),
        .count    (outstanding_count)
    );
    assign if_read_data       = bus_read_data;
    assign dm_read_data       = bus_read_data;
    assign if_read_data_valid = pop & (head == MASTER_IFETCH);
    assign dm_read_data_valid = pop & (head == MASTER_DATA);
    assign protocol_error     = protocol_error_q;
endmodule

// File: tb/tb_system_bus_arbiter.sv
// tb_system_bus_arbiter: directed scenarios plus randomized traffic against a queue-based model
module tb_system_bus_arbiter;
    import system_bus_pkg::*;
    localparam int MAX = 4;
    logic clk = 1'b0;
    logic reset_n;
    logic if_ready, dm_ready;
    logic [29:0] if_addr, dm_addr, bus_addr;
    logic [31:0] dm_write_data, if_read_data, dm_read_data, bus_write_data, bus_read_data;
    logic [3:0] if_byte_enable, dm_byte_enable, bus_byte_enable;
    logic if_read_req, dm_read_req, dm_write_req, if_read_data_valid, dm_read_data_valid;
    logic bus_ready, bus_read_req, bus_write_req, bus_read_data_valid, protocol_error;
    logic [2:0] outstanding_count;
    int total = 0;
    int bad = 0;
    int tags[$];
    int last_g;
    bit m_perr;
    int g;
    logic [9:0] e_vec;
    logic [29:0] e_addr;
    logic [31:0] e_wd;
    logic [3:0] e_be;
    wire [9:0] act = {if_ready, dm_ready, bus_read_req, bus_write_req, if_read_data_valid,
                      dm_read_data_valid, outstanding_count, protocol_error};

    system_bus_arbiter #(.MAX_OUTSTANDING(MAX)) dut (
        .clk(clk), .reset_n(reset_n),
        .if_ready(if_ready), .if_addr(if_addr), .if_byte_enable(if_byte_enable),
        .if_read_req(if_read_req), .if_read_data(if_read_data), .if_read_data_valid(if_read_data_valid),
        .dm_ready(dm_ready), .dm_addr(dm_addr), .dm_write_data(dm_write_data),
        .dm_byte_enable(dm_byte_enable), .dm_read_req(dm_read_req), .dm_write_req(dm_write_req),
        .dm_read_data(dm_read_data), .dm_read_data_valid(dm_read_data_valid),
        .bus_ready(bus_ready), .bus_addr(bus_addr), .bus_write_data(bus_write_data),
        .bus_byte_enable(bus_byte_enable), .bus_read_req(bus_read_req), .bus_write_req(bus_write_req),
        .bus_read_data(bus_read_data), .bus_read_data_valid(bus_read_data_valid),
        .outstanding_count(outstanding_count), .protocol_error(protocol_error)
    );

    always #5 clk = ~clk;

    // Reference model: who wins, what the bus sees, and which master owns the oldest read
    function automatic void model_eval();
        bit full, ie, de, ret;
        full = tags.size() >= MAX;
        ie = if_read_req && !full;
        de = (dm_write_req && !dm_read_req) || (dm_read_req && !full);
        ret = bus_read_data_valid && tags.size() > 0;
        g = (ie && de) ? 1 - last_g : ie ? 0 : de ? 1 : -1;
        e_vec = {bus_ready && g == 0, bus_ready && g == 1, g == 0 || (g == 1 && dm_read_req),
                 g == 1 && dm_write_req && !dm_read_req, ret && tags[0] == 0, ret && tags[0] == 1,
                 3'(tags.size()), m_perr};
        e_addr = (g == 1) ? dm_addr : if_addr;
        e_wd = (g == 1) ? dm_write_data : 32'h0;
        e_be = (g == 1) ? dm_byte_enable : if_byte_enable;
    endfunction

    function automatic void model_step();
        if (bus_read_data_valid) begin
            if (tags.size() > 0) void'(tags.pop_front());
            else m_perr = 1;
        end
        if (dm_read_req && dm_write_req) m_perr = 1;
        if (bus_ready && g >= 0) begin
            last_g = g;
            if (g == 0 || dm_read_req) tags.push_back(g);
        end
    endfunction

    task automatic idle();
        if_read_req = 0; dm_read_req = 0; dm_write_req = 0;
        bus_ready = 0; bus_read_data_valid = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset_n = 0;
        cyc();
        reset_n = 1;
        tags.delete();
        last_g = 0;
        m_perr = 0;
    endtask

    task automatic test_reset();
        reset_n = 0; if_read_req = 1; dm_read_req = 1; dm_write_req = 0;
        bus_ready = 1; bus_read_data_valid = 1;
        #1;
        total++;
        if (act !== 10'b0) begin bad++; $display("FAIL reset_async: got %b want %b", act, 10'b0); end
        cyc();
        total++;
        if (act !== 10'b0) begin bad++; $display("FAIL reset_held: got %b want %b", act, 10'b0); end
        idle();
        reset_n = 1;
        #1;
        total++;
        if ({outstanding_count, protocol_error} !== 4'b0) begin
            bad++; $display("FAIL reset_release: got %b want 0000", {outstanding_count, protocol_error});
        end
    endtask

    task automatic test_single_read();
        do_reset();
        if_addr = 30'h0ABC_1234; dm_addr = 30'h0111_2222; if_byte_enable = 4'hF;
        if_read_req = 1; bus_ready = 1;
        #1;
        total++;
        if (bus_addr !== 30'h0ABC_1234) begin bad++; $display("FAIL single_addr: got %h want %h", bus_addr, 30'h0ABC_1234); end
        total++;
        if ({if_ready, dm_ready, bus_read_req, outstanding_count} !== 6'b101_000) begin
            bad++; $display("FAIL single_grant: got %b want 101000", {if_ready, dm_ready, bus_read_req, outstanding_count});
        end
        cyc();
        if_read_req = 0;
        #1;
        total++;
        if (outstanding_count !== 3'd1) begin bad++; $display("FAIL single_count1: got %0d want 1", outstanding_count); end
        cyc();
        cyc();
        bus_read_data_valid = 1; bus_read_data = 32'h1234_5678;
        #1;
        total++;
        if ({if_read_data_valid, dm_read_data_valid, if_read_data} !== {2'b10, 32'h1234_5678}) begin
            bad++; $display("FAIL single_return: got %b %h want 10 12345678", {if_read_data_valid, dm_read_data_valid}, if_read_data);
        end
        cyc();
        bus_read_data_valid = 0;
        #1;
        total++;
        if ({outstanding_count, if_read_data_valid, dm_read_data_valid} !== 5'b0) begin
            bad++; $display("FAIL single_drain: got %b want 00000", {outstanding_count, if_read_data_valid, dm_read_data_valid});
        end
    endtask

    task automatic test_alternation();
        bit exp_dm [7] = '{1, 0, 1, 0, 0, 0, 1};
        bit rdy [7] = '{1, 1, 1, 0, 0, 1, 1};
        do_reset();
        if_read_req = 1; dm_write_req = 1; dm_addr = 30'h0222_0000; if_addr = 30'h0333_0000;
        for (int i = 0; i < 7; i++) begin
            bus_ready = rdy[i];
            #1;
            total++;
            if ({if_ready, dm_ready, bus_read_req, bus_write_req, bus_addr} !==
                {rdy[i] & ~exp_dm[i], rdy[i] & exp_dm[i], ~exp_dm[i], exp_dm[i], exp_dm[i] ? dm_addr : if_addr}) begin
                bad++; $display("FAIL alt_cycle%0d: got %b %h want dm_grant=%0d ready=%0d", i,
                                {if_ready, dm_ready, bus_read_req, bus_write_req}, bus_addr, exp_dm[i], rdy[i]);
            end
            cyc();
        end
        idle();
    endtask

    task automatic test_full();
        do_reset();
        dm_read_req = 1; bus_ready = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if ({dm_ready, bus_read_req} !== 2'b11) begin bad++; $display("FAIL full_fill%0d: got %b want 11", i, {dm_ready, bus_read_req}); end
            cyc();
        end
        total++;
        if ({dm_ready, outstanding_count} !== {1'b0, 3'd4}) begin
            bad++; $display("FAIL full_block: got %b want 0100", {dm_ready, outstanding_count});
        end
        dm_read_req = 0; dm_write_req = 1; if_read_req = 1;
        #1;
        total++;
        if ({if_ready, dm_ready, bus_write_req, bus_read_req} !== 4'b0110) begin
            bad++; $display("FAIL full_write_pass: got %b want 0110", {if_ready, dm_ready, bus_write_req, bus_read_req});
        end
        cyc();
        dm_write_req = 0; bus_read_data_valid = 1;
        #1;
        total++;
        if ({if_ready, dm_read_data_valid, bus_read_req} !== 3'b010) begin
            bad++; $display("FAIL full_no_bypass: got %b want 010", {if_ready, dm_read_data_valid, bus_read_req});
        end
        cyc();
        bus_read_data_valid = 0;
        #1;
        total++;
        if ({if_ready, outstanding_count} !== {1'b1, 3'd3}) begin
            bad++; $display("FAIL full_next_read: got %b want 1011", {if_ready, outstanding_count});
        end
        cyc();
        idle();
    endtask

    task automatic test_interleaved_returns();
        int seq [4] = '{0, 1, 1, 0};
        do_reset();
        bus_ready = 1;
        for (int i = 0; i < 4; i++) begin
            if_read_req = (seq[i] == 0); dm_read_req = (seq[i] == 1);
            cyc();
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            bus_read_data_valid = 1; bus_read_data = 32'hA + 32'(i);
            #1;
            total++;
            if ({if_read_data_valid, dm_read_data_valid, dm_read_data} !== {seq[i] == 0, seq[i] == 1, 32'hA + 32'(i)}) begin
                bad++; $display("FAIL ret%0d: got %b %h want owner=%0d data=%h", i,
                                {if_read_data_valid, dm_read_data_valid}, dm_read_data, seq[i], 32'hA + 32'(i));
            end
            cyc();
        end
        bus_read_data_valid = 0;
        #1;
        total++;
        if ({outstanding_count, protocol_error} !== 4'b0) begin
            bad++; $display("FAIL ret_drain: got %b want 0000", {outstanding_count, protocol_error});
        end
    endtask

    task automatic test_underflow();
        do_reset();
        bus_read_data_valid = 1;
        #1;
        total++;
        if ({if_read_data_valid, dm_read_data_valid, outstanding_count} !== 5'b0) begin
            bad++; $display("FAIL under_valid: got %b want 00000", {if_read_data_valid, dm_read_data_valid, outstanding_count});
        end
        cyc();
        bus_read_data_valid = 0;
        #1;
        total++;
        if (protocol_error !== 1'b1) begin bad++; $display("FAIL under_err: got %b want 1", protocol_error); end
        repeat (3) cyc();
        total++;
        if ({protocol_error, outstanding_count} !== 4'b1000) begin
            bad++; $display("FAIL under_sticky: got %b want 1000", {protocol_error, outstanding_count});
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        bus_ready = 1; if_read_req = 1;
        cyc();
        if_read_req = 0; dm_read_req = 1;
        cyc();
        if_read_req = 1;
        #1;
        total++;
        if (outstanding_count !== 3'd2) begin bad++; $display("FAIL mid_count: got %0d want 2", outstanding_count); end
        reset_n = 0;
        #1;
        total++;
        if ({outstanding_count, bus_read_req, bus_write_req, if_ready, dm_ready} !== 7'b0) begin
            bad++; $display("FAIL mid_reset: got %b want 0000000", {outstanding_count, bus_read_req, bus_write_req, if_ready, dm_ready});
        end
        cyc();
        reset_n = 1;
        #1;
        total++;
        if ({dm_ready, if_ready} !== 2'b10) begin bad++; $display("FAIL mid_first_grant: got %b want 10", {dm_ready, if_ready}); end
        cyc();
        idle();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if_addr = 30'($urandom); dm_addr = 30'($urandom);
            dm_write_data = $urandom; bus_read_data = $urandom;
            if_byte_enable = 4'($urandom); dm_byte_enable = 4'($urandom);
            if_read_req = ($urandom_range(0, 1) == 1);
            dm_read_req = ($urandom_range(0, 2) == 0);
            dm_write_req = dm_read_req ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 2) == 0);
            bus_ready = ($urandom_range(0, 3) != 0);
            bus_read_data_valid = (tags.size() > 0) ? ($urandom_range(0, 4) < 2) : ($urandom_range(0, 39) == 0);
            #1;
            model_eval();
            total++;
            if (act !== e_vec) begin bad++; $display("FAIL rand%0d_ctrl: got %b want %b", i, act, e_vec); end
            total++;
            if ({bus_addr, bus_write_data, bus_byte_enable} !== {e_addr, e_wd, e_be}) begin
                bad++; $display("FAIL rand%0d_mux: got %h %h %h want %h %h %h", i,
                                bus_addr, bus_write_data, bus_byte_enable, e_addr, e_wd, e_be);
            end
            total++;
            if ({if_read_data, dm_read_data} !== {bus_read_data, bus_read_data}) begin
                bad++; $display("FAIL rand%0d_rdata: got %h %h want %h", i, if_read_data, dm_read_data, bus_read_data);
            end
            model_step();
            cyc();
        end
        idle();
    endtask

    initial begin
        if_addr = 0; dm_addr = 0; dm_write_data = 0; bus_read_data = 0;
        if_byte_enable = 0; dm_byte_enable = 0;
        idle();
        reset_n = 1;
        #2;
        test_reset();
        test_single_read();
        test_alternation();
        test_full();
        test_interleaved_returns();
        test_underflow();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
